break_sequence_control: RTL and testbench

Cycle sequencer for the break/interrupt/reset entry sequence, directly downstream of interrupt and reset control. Consumes `aic_n`, `res_g` and `nmi_sel` and drives the full six-cycle vector entry: dummy read, three stack pushes, and two vector-byte fetches. Pushes are converted to reads during reset. Emits the loaded PC, the new stack pointer and the interrupt-mask set strobe to the register section.

---
 rtl/break_sequence_control.sv | 181 ++++++++++++++++++
 tb/tb_break_sequence_control.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/break_sequence_control.sv
// Six-cycle break/interrupt/reset entry sequencer: dummy read, three stack
// pushes, two vector-byte fetches, then a one-cycle load strobe to the
// register section.
module break_sequence_control (
    input  logic        clk_1,
    input  logic        res_p,
    input  logic        rdy,
    input  logic        fetch_t0,
    input  logic        brk_op,
    input  logic        aic_n,
    input  logic        res_g,
    input  logic        nmi_sel,
    input  logic [15:0] pc_in,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  p_in,
    input  logic [7:0]  data_in,
    output logic [15:0] addr,
    output logic        rw,
    output logic [7:0]  data_out,
    output logic        busy,
    output logic        vec_lo,
    output logic [15:0] pc_out,
    output logic        pc_load,
    output logic [7:0]  sp_out,
    output logic        sp_load,
    output logic        set_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;          // PC as captured (dummy-read address)
    logic [7:0]  sp_q, sp_d;          // working stack pointer
    logic [7:0]  p_q, p_d;            // status byte already formatted for push
    logic        irq_mode_q, irq_mode_d;
    logic        rst_mode_q, rst_mode_d;
    logic [7:0]  vec_q, vec_d;        // low byte of the selected vector address
    logic [15:0] addr_hold_q, addr_hold_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic [7:0]  sp_out_q, sp_out_d;
    logic        done_q, done_d;

    logic [15:0] pc_push;
    logic [7:0]  push_byte;
    logic        push_cycle;
    logic        start;
    logic        advance;

    // Bus decode from registered state only; IDLE keeps the last address.
    always_comb begin
        pc_push    = irq_mode_q ? pc_q : pc_q + 16'd1;
        addr       = addr_hold_q;
        rw         = 1'b1;
        data_out   = 8'h00;
        push_byte  = 8'h00;
        push_cycle = 1'b0;
        busy       = (state_q != S_IDLE);
        vec_lo     = (state_q == S_T5);
        case (state_q)
            S_T1: addr = pc_q;
            S_T2: begin
                addr       = {8'h01, sp_q};
                push_byte  = pc_push[15:8];
                push_cycle = 1'b1;
            end
            S_T3: begin
                addr       = {8'h01, sp_q};
                push_byte  = pc_push[7:0];
                push_cycle = 1'b1;
            end
            S_T4: begin
                addr       = {8'h01, sp_q};
                push_byte  = p_q;
                push_cycle = 1'b1;
            end
            S_T5: addr = {8'hFF, vec_q};
            S_T6: addr = {8'hFF, vec_q + 8'd1};
            default: ;
        endcase
        // During reset the pushes become reads so memory is left untouched.
        if (push_cycle && !rst_mode_q) begin
            rw       = 1'b0;
            data_out = push_byte;
        end
        start   = (state_q == S_IDLE) && fetch_t0 && rdy && (!aic_n || brk_op);
        advance = (state_q != S_IDLE) && (!rw || rdy);
    end

    // Next-state, capture and completion logic.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        sp_d        = sp_q;
        p_d         = p_q;
        irq_mode_d  = irq_mode_q;
        rst_mode_d  = rst_mode_q;
        vec_d       = vec_q;
        pc_out_d    = pc_out_q;
        sp_out_d    = sp_out_q;
        done_d      = 1'b0;
        addr_hold_d = busy ? addr : addr_hold_q;
        if (start) begin
            state_d    = S_T1;
            pc_d       = pc_in;
            sp_d       = sp_in;
            // Bit5 forced high; B set only for a software BRK (aic_n high).
            p_d        = {p_in[7:6], 1'b1, aic_n, p_in[3:0]};
            irq_mode_d = !aic_n;
            rst_mode_d = res_g;
        end else if (advance) begin
            case (state_q)
                S_T1: state_d = S_T2;
                S_T2: begin
                    sp_d    = sp_q - 8'd1;
                    state_d = S_T3;
                end
                S_T3: begin
                    sp_d    = sp_q - 8'd1;
                    state_d = S_T4;
                end
                S_T4: begin
                    sp_d    = sp_q - 8'd1;
                    state_d = S_T5;
                    // Late NMI can still hijack a BRK/IRQ entry here.
                    if (res_g)        vec_d = 8'hFC;
                    else if (nmi_sel) vec_d = 8'hFA;
                    else              vec_d = 8'hFE;
                end
                S_T5: begin
                    pc_out_d[7:0] = data_in;
                    state_d       = S_T6;
                end
                S_T6: begin
                    pc_out_d[15:8] = data_in;
                    sp_out_d       = sp_q;
                    done_d         = 1'b1;
                    state_d        = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register with asynchronous abort.
    always_ff @(posedge clk_1 or posedge res_p) begin
        if (res_p) begin
            state_q     <= S_IDLE;
            pc_q        <= 16'h0000;
            sp_q        <= 8'h00;
            p_q         <= 8'h00;
            irq_mode_q  <= 1'b0;
            rst_mode_q  <= 1'b0;
            vec_q       <= 8'h00;
            addr_hold_q <= 16'h0000;
            pc_out_q    <= 16'h0000;
            sp_out_q    <= 8'h00;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            sp_q        <= sp_d;
            p_q         <= p_d;
            irq_mode_q  <= irq_mode_d;
            rst_mode_q  <= rst_mode_d;
            vec_q       <= vec_d;
            addr_hold_q <= addr_hold_d;
            pc_out_q    <= pc_out_d;
            sp_out_q    <= sp_out_d;
            done_q      <= done_d;
        end
    end

    assign pc_out  = pc_out_q;
    assign sp_out  = sp_out_q;
    assign pc_load = done_q;
    assign sp_load = done_q;
    assign set_i   = done_q;

endmodule

// File: tb/tb_break_sequence_control.sv
// Scoreboard bench: stimulus queues expected bus cycles and completions,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_break_sequence_control;

    logic        clk_1 = 1'b0;
    logic        res_p, rdy, fetch_t0, brk_op, aic_n, res_g, nmi_sel;
    logic [15:0] pc_in;
    logic [7:0]  sp_in, p_in, data_in;
    logic [15:0] addr, pc_out;
    logic        rw, busy, vec_lo, pc_load, sp_load, set_i;
    logic [7:0]  data_out, sp_out;

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  data;
        logic        chk_data;
        logic        vl;
    } bus_t;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  sp;
        int          cyc;
    } done_t;

    bus_t  bus_q[$];
    done_t done_q[$];
    bus_t  mb;
    done_t md;
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    c0;

    always #5 clk_1 = ~clk_1;
    always @(posedge clk_1) cyc <= cyc + 1;

    break_sequence_control dut (
        .clk_1(clk_1), .res_p(res_p), .rdy(rdy), .fetch_t0(fetch_t0),
        .brk_op(brk_op), .aic_n(aic_n), .res_g(res_g), .nmi_sel(nmi_sel),
        .pc_in(pc_in), .sp_in(sp_in), .p_in(p_in), .data_in(data_in),
        .addr(addr), .rw(rw), .data_out(data_out), .busy(busy),
        .vec_lo(vec_lo), .pc_out(pc_out), .pc_load(pc_load),
        .sp_out(sp_out), .sp_load(sp_load), .set_i(set_i)
    );

    // Vector ROM seen by the DUT read bus.
    always_comb begin
        case (addr)
            16'hFFFA: data_in = 8'h34;
            16'hFFFB: data_in = 8'h90;
            16'hFFFC: data_in = 8'h5A;
            16'hFFFD: data_in = 8'hA0;
            16'hFFFE: data_in = 8'h00;
            16'hFFFF: data_in = 8'h80;
            default:  data_in = 8'hEA;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one bus transaction per completed cycle, one per strobe.
    always @(negedge clk_1) begin
        if (!res_p) begin
            if (busy && (!rw || rdy)) begin
                if (bus_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_bus: addr %h rw %b, nothing expected", addr, rw);
                end else begin
                    mb = bus_q.pop_front();
                    check("addr", {16'h0, addr}, {16'h0, mb.addr});
                    check("rw", {31'h0, rw}, {31'h0, mb.rw});
                    if (mb.chk_data) check("data_out", {24'h0, data_out}, {24'h0, mb.data});
                    check("vec_lo", {31'h0, vec_lo}, {31'h0, mb.vl});
                    $display("bus   addr=%h rw=%b data_out=%h vec_lo=%b", addr, rw, data_out, vec_lo);
                end
            end
            if (pc_load || sp_load || set_i) begin
                if (done_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_strobe: pc_out %h sp_out %h", pc_out, sp_out);
                end else begin
                    md = done_q.pop_front();
                    check("pc_out", {16'h0, pc_out}, {16'h0, md.pc});
                    check("sp_out", {24'h0, sp_out}, {24'h0, md.sp});
                    check("strobes", {29'h0, pc_load, sp_load, set_i}, 32'h7);
                    check("strobe_cycle", cyc, md.cyc);
                    $display("done  pc_out=%h sp_out=%h cycle=%0d", pc_out, sp_out, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    task automatic bus(input logic [15:0] a, input logic r, input logic [7:0] d,
                       input logic c, input logic v);
        bus_t e;
        e.addr = a; e.rw = r; e.data = d; e.chk_data = c; e.vl = v;
        bus_q.push_back(e);
    endtask

    task automatic done(input logic [15:0] pc, input logic [7:0] sp, input int at);
        done_t e;
        e.pc = pc; e.sp = sp; e.cyc = at;
        done_q.push_back(e);
    endtask

    // Present one start request; returns the cycle counter seen in cycle 1.
    task automatic start(input logic a_n, input logic brk, input logic [15:0] pc,
                         input logic [7:0] sp, input logic [7:0] p, output int c_first);
        aic_n = a_n; brk_op = brk; pc_in = pc; sp_in = sp; p_in = p;
        fetch_t0 = 1'b1; rdy = 1'b1;
        tick();
        c_first = cyc;
        fetch_t0 = 1'b0; aic_n = 1'b1; brk_op = 1'b0;
        pc_in = 16'h0; sp_in = 8'h0; p_in = 8'h0;
    endtask

    // Bounded drain: anything still queued means the DUT never presented it.
    task automatic drain();
        repeat (10) tick();
        check("bus_q_drained", bus_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
    endtask

    task automatic check_reset_values();
        check("rst_addr", {16'h0, addr}, 32'h0);
        check("rst_rw", {31'h0, rw}, 32'h1);
        check("rst_data_out", {24'h0, data_out}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_vec_lo", {31'h0, vec_lo}, 32'h0);
        check("rst_pc_out", {16'h0, pc_out}, 32'h0);
        check("rst_sp_out", {24'h0, sp_out}, 32'h0);
        check("rst_strobes", {29'h0, pc_load, sp_load, set_i}, 32'h0);
    endtask

    initial begin
        res_p = 1'b1; rdy = 1'b1; fetch_t0 = 1'b0; brk_op = 1'b0; aic_n = 1'b1;
        res_g = 1'b0; nmi_sel = 1'b0; pc_in = 16'h0; sp_in = 8'h0; p_in = 8'h0;
        #1;
        check_reset_values();
        tick(); tick();
        res_p = 1'b0;
        tick();

        // IRQ entry
        bus(16'h1234, 1, 8'h00, 0, 0);
        bus(16'h01FD, 0, 8'h12, 1, 0);
        bus(16'h01FC, 0, 8'h34, 1, 0);
        bus(16'h01FB, 0, 8'h20, 1, 0);
        bus(16'hFFFE, 1, 8'h00, 0, 1);
        bus(16'hFFFF, 1, 8'h00, 0, 0);
        start(1'b0, 1'b0, 16'h1234, 8'hFD, 8'h00, c0);
        done(16'h8000, 8'hFA, c0 + 6);
        drain();
        check("idle_addr_hold", {16'h0, addr}, 32'hFFFF);
        check("idle_rw", {31'h0, rw}, 32'h1);

        // Software BRK: pushes PC+1 with B set
        bus(16'h12FF, 1, 8'h00, 0, 0);
        bus(16'h01FF, 0, 8'h13, 1, 0);
        bus(16'h01FE, 0, 8'h00, 1, 0);
        bus(16'h01FD, 0, 8'h31, 1, 0);
        bus(16'hFFFE, 1, 8'h00, 0, 1);
        bus(16'hFFFF, 1, 8'h00, 0, 0);
        start(1'b1, 1'b1, 16'h12FF, 8'hFF, 8'h01, c0);
        done(16'h8000, 8'hFC, c0 + 6);
        drain();

        // BRK at PC FFFF wraps to 0000; SP walks down through 0100
        bus(16'hFFFF, 1, 8'h00, 0, 0);
        bus(16'h0102, 0, 8'h00, 1, 0);
        bus(16'h0101, 0, 8'h00, 1, 0);
        bus(16'h0100, 0, 8'hFF, 1, 0);
        bus(16'hFFFE, 1, 8'h00, 0, 1);
        bus(16'hFFFF, 1, 8'h00, 0, 0);
        start(1'b1, 1'b1, 16'hFFFF, 8'h02, 8'hFF, c0);
        done(16'h8000, 8'hFF, c0 + 6);
        drain();

        // Reset entry: pushes become reads, SP wraps 00 -> FF
        res_g = 1'b1;
        bus(16'hABCD, 1, 8'h00, 0, 0);
        bus(16'h0100, 1, 8'h00, 1, 0);
        bus(16'h01FF, 1, 8'h00, 1, 0);
        bus(16'h01FE, 1, 8'h00, 1, 0);
        bus(16'hFFFC, 1, 8'h00, 0, 1);
        bus(16'hFFFD, 1, 8'h00, 0, 0);
        start(1'b0, 1'b0, 16'hABCD, 8'h00, 8'h00, c0);
        done(16'hA05A, 8'hFD, c0 + 6);
        drain();
        res_g = 1'b0;

        // NMI raised in T3 hijacks an IRQ entry to FFFA, B stays clear
        bus(16'h4000, 1, 8'h00, 0, 0);
        bus(16'h0180, 0, 8'h40, 1, 0);
        bus(16'h017F, 0, 8'h00, 1, 0);
        bus(16'h017E, 0, 8'hE3, 1, 0);
        bus(16'hFFFA, 1, 8'h00, 0, 1);
        bus(16'hFFFB, 1, 8'h00, 0, 0);
        start(1'b0, 1'b0, 16'h4000, 8'h80, 8'hC3, c0);
        done(16'h9034, 8'h7D, c0 + 6);
        tick(); tick();
        nmi_sel = 1'b1;
        tick(); tick(); tick();
        nmi_sel = 1'b0;
        drain();

        // rdy low in the write cycles T2/T3 (no effect) and twice in T5
        bus(16'h0055, 1, 8'h00, 0, 0);
        bus(16'h0110, 0, 8'h00, 1, 0);
        bus(16'h010F, 0, 8'h55, 1, 0);
        bus(16'h010E, 0, 8'h2F, 1, 0);
        bus(16'hFFFE, 1, 8'h00, 0, 1);
        bus(16'hFFFF, 1, 8'h00, 0, 0);
        start(1'b0, 1'b0, 16'h0055, 8'h10, 8'h0F, c0);
        done(16'h8000, 8'h0D, c0 + 8);
        tick(); rdy = 1'b0;
        tick();
        tick(); rdy = 1'b1;
        tick(); rdy = 1'b0;
        check("stall_vec_lo", {31'h0, vec_lo}, 32'h1);
        tick();
        check("stall_hold_addr", {16'h0, addr}, 32'hFFFE);
        tick(); rdy = 1'b1;
        drain();

        // Asynchronous reset in T4 aborts with no strobes afterwards
        bus(16'h2000, 1, 8'h00, 0, 0);
        bus(16'h0150, 0, 8'h20, 1, 0);
        bus(16'h014F, 0, 8'h01, 1, 0);
        start(1'b1, 1'b1, 16'h2000, 8'h50, 8'h00, c0);
        tick(); tick(); tick();
        res_p = 1'b1;
        #1;
        check_reset_values();
        tick();
        res_p = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
